// File: rtl/config_loader.sv
// ---------------------------------------------------------------------------
// config_loader
//
// Loads a fabric configuration image from a stream of DATA_WIDTH-bit words.
// Words are shifted into a shadow register, first word ending up most
// significant. Once all WORDS words are in, the image moves to config_out in a
// single edge. The fabric muxes driven by config_out therefore never see a
// partially loaded image.
//
// Optional feature macro: CONFIG_READBACK_EN
//   When defined, the shadow is preloaded with the active image at start or
//   restart. Each accepted word shifts one old-image word out of the top of the
//   shadow onto readback_out/readback_valid, most significant word first.
//   When undefined, the readback ports are absent and the shadow is cleared at
//   start.
//
// Ports
//   clock          in   rising-edge clock
//   nreset         in   asynchronous active-low reset
//   start          in   begin a load (restarts the load if already loading)
//   data_in        in   bitstream word
//   data_valid     in   data_in is valid
//   data_ready     out  loader accepts a word this cycle (high in LOAD only)
//   busy           out  state is not IDLE
//   done           out  one-cycle pulse; new image visible on config_out
//   error          out  one-cycle pulse; load aborted by a restart
//   config_out     out  active configuration image
//   readback_out   out  old-image word      (CONFIG_READBACK_EN only)
//   readback_valid out  readback_out valid  (CONFIG_READBACK_EN only)
//   state_dbg      out  current FSM state (0 IDLE, 1 LOAD, 2 COMMIT)
//
// Handshake: a word transfers on a rising edge where data_valid && data_ready
// are both high. data_ready depends only on the state, never on data_valid.
// The source may hold data_valid low for any number of cycles. Once asserted,
// data_in must stay stable until the transfer edge.
// ---------------------------------------------------------------------------
module config_loader #(
  parameter int CONFIG_WIDTH = 40,
  parameter int DATA_WIDTH   = 8
) (
  input  logic                    clock,
  input  logic                    nreset,
  input  logic                    start,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CONFIG_WIDTH-1:0] config_out,
`ifdef CONFIG_READBACK_EN
  output logic [DATA_WIDTH-1:0]   readback_out,
  output logic                    readback_valid,
`endif
  output logic [1:0]              state_dbg
);

  localparam int WORDS        = (CONFIG_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int SHADOW_WIDTH = WORDS * DATA_WIDTH;
  localparam int COUNT_WIDTH  = $clog2(WORDS + 1);
  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t                  state;
  logic [SHADOW_WIDTH-1:0] shadow;
  logic [SHADOW_WIDTH-1:0] init_image;
  logic [SHADOW_WIDTH-1:0] shifted;
  logic [COUNT_WIDTH-1:0]  count;
  logic                    accept;

  assign data_ready = (state == LOAD);
  assign busy       = (state != IDLE);
  assign state_dbg  = state;
  assign accept     = data_ready && data_valid;

  // Shift left by one word and append the new word.
  // With WORDS == 1 the shift clears the whole register, which is intended.
  assign shifted = (shadow << DATA_WIDTH) | SHADOW_WIDTH'(data_in);

  // Value the shadow is (re)initialised to at start, restart and in IDLE.
  always_comb begin
    init_image = '0;
`ifdef CONFIG_READBACK_EN
    init_image[CONFIG_WIDTH-1:0] = config_out;
`endif
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state          <= IDLE;
      shadow         <= '0;
      count          <= '0;
      config_out     <= '0;
      done           <= 1'b0;
      error          <= 1'b0;
`ifdef CONFIG_READBACK_EN
      readback_out   <= '0;
      readback_valid <= 1'b0;
`endif
    end else begin
      done           <= 1'b0;
      error          <= 1'b0;
`ifdef CONFIG_READBACK_EN
      readback_valid <= 1'b0;
`endif
      case (state)
        IDLE: begin
          count  <= '0;
          shadow <= init_image;
          if (start) begin
            state <= LOAD;
          end
        end

        LOAD: begin
          if (start) begin
            // A restart wins over a simultaneous accept; that word is dropped.
            count  <= '0;
            shadow <= init_image;
            error  <= 1'b1;
          end else if (accept) begin
            shadow <= shifted;
            count  <= count + 1'b1;
`ifdef CONFIG_READBACK_EN
            readback_out   <= shadow[SHADOW_WIDTH-1 -: DATA_WIDTH];
            readback_valid <= 1'b1;
`endif
            if (count == LAST_COUNT) begin
              state <= COMMIT;
            end
          end
        end

        COMMIT: begin
          // Surplus top bits of a non-multiple image drop out here.
          config_out <= shadow[CONFIG_WIDTH-1:0];
          done       <= 1'b1;
          state      <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// ---------------------------------------------------------------------------
// tb_config_loader
//
// Directed bench for config_loader. u_dut uses the default 40-bit image.
// u_dut36 uses a 36-bit image for the non-multiple-width case.
// Inputs are driven 1 ns after the rising edge, and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_config_loader;

  // ---------------- clock / reset ----------------
  logic        clock = 1'b0;
  logic        nreset;

  always #5 clock = ~clock;

  // ---------------- 40-bit instance ----------------
  logic        start;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [39:0] config_out;
  logic [1:0]  state_dbg;
`ifdef CONFIG_READBACK_EN
  logic [7:0]  readback_out;
  logic        readback_valid;
`endif

  // ---------------- 36-bit instance ----------------
  logic        start36;
  logic [7:0]  data36;
  logic        valid36;
  logic        ready36;
  logic        busy36;
  logic        done36;
  logic        error36;
  logic [35:0] config36;
  logic [1:0]  state36;
`ifdef CONFIG_READBACK_EN
  logic [7:0]  rb_out36;
  logic        rb_valid36;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  config_loader #(.CONFIG_WIDTH(40), .DATA_WIDTH(8)) u_dut (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .config_out     (config_out),
`ifdef CONFIG_READBACK_EN
    .readback_out   (readback_out),
    .readback_valid (readback_valid),
`endif
    .state_dbg      (state_dbg)
  );

  config_loader #(.CONFIG_WIDTH(36), .DATA_WIDTH(8)) u_dut36 (
    .clock          (clock),
    .nreset         (nreset),
    .start          (start36),
    .data_in        (data36),
    .data_valid     (valid36),
    .data_ready     (ready36),
    .busy           (busy36),
    .done           (done36),
    .error          (error36),
    .config_out     (config36),
`ifdef CONFIG_READBACK_EN
    .readback_out   (rb_out36),
    .readback_valid (rb_valid36),
`endif
    .state_dbg      (state36)
  );

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] w);
    data_in    = w;
    data_valid = 1'b1;
    step();
    data_valid = 1'b0;
  endtask

  task automatic apply_reset();
    nreset = 1'b0;
    step();
    nreset = 1'b1;
    step();
  endtask

  // start, five back-to-back words, then the COMMIT edge
  task automatic load_full(input logic [39:0] img);
    do_start();
    for (int i = 0; i < 5; i++) send_word(img[39-8*i -: 8]);
    step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    nreset = 1'b0;
    #2;
    n_checks++; if (config_out !== 40'h0) begin n_fail++; $display("FAIL reset_config: got %h expected %h", config_out, 40'h0); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", state_dbg); end
    n_checks++; if ({busy, done, error, data_ready} !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b expected 0000", {busy, done, error, data_ready}); end
    n_checks++; if (config36 !== 36'h0) begin n_fail++; $display("FAIL reset_config36: got %h expected 0", config36); end
`ifdef CONFIG_READBACK_EN
    n_checks++; if ({readback_valid, readback_out} !== 9'h0) begin n_fail++; $display("FAIL reset_readback: got %b/%h expected 0/00", readback_valid, readback_out); end
`endif
    step();
    nreset = 1'b1;
    step();
  endtask

  task automatic test_basic_load();
    do_start();
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready_after_start: got %b expected 1", data_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_load: got %b expected 1", busy); end
    send_word(8'h12); send_word(8'h34); send_word(8'h56); send_word(8'h78);
    send_word(8'h9A);
    // COMMIT cycle: not ready, still busy, image not yet visible
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ready_commit: got %b expected 0", data_ready); end
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_commit: got %b expected 1", busy); end
    n_checks++; if (config_out !== 40'h0) begin n_fail++; $display("FAIL basic_config_before_commit: got %h expected 0", config_out); end
    // start during COMMIT must be ignored
    start = 1'b1;
    step();
    start = 1'b0;
    n_checks++; if (config_out !== 40'h123456789A) begin n_fail++; $display("FAIL basic_config: got %h expected %h", config_out, 40'h123456789A); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL basic_done: got %b expected 1", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_done_cycle: got %b expected 0", busy); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL basic_commit_ignores_start: got state %0d expected 0", state_dbg); end
    step();
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_one_cycle: got %b expected 0", done); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_stalls();
    logic [39:0] img;
    img = 40'h123456789A;
    apply_reset();
    do_start();
    for (int i = 0; i < 5; i++) begin
      send_word(img[39-8*i -: 8]);
      if (i < 4) begin
        for (int s = 0; s < 3; s++) begin
          step();
          n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL stall_ready w%0d s%0d: got %b expected 1", i, s, data_ready); end
          n_checks++; if (config_out !== 40'h0) begin n_fail++; $display("FAIL stall_config w%0d s%0d: got %h expected 0", i, s, config_out); end
        end
      end
    end
    n_checks++; if (state_dbg !== 2'd2) begin n_fail++; $display("FAIL stall_commit_state: got %0d expected 2", state_dbg); end
    step();
    n_checks++; if (config_out !== 40'h123456789A) begin n_fail++; $display("FAIL stall_config_final: got %h expected %h", config_out, 40'h123456789A); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL stall_done: got %b expected 1", done); end
    step();
  endtask

  task automatic test_restart();
    int done_count;
    done_count = 0;
    do_start();
    send_word(8'hAA); send_word(8'hBB);
    // restart with a simultaneous valid word, which must be discarded
    start      = 1'b1;
    data_in    = 8'hCC;
    data_valid = 1'b1;
    step();
    start      = 1'b0;
    data_valid = 1'b0;
    n_checks++; if (error !== 1'b1) begin n_fail++; $display("FAIL restart_error: got %b expected 1", error); end
    n_checks++; if (state_dbg !== 2'd1) begin n_fail++; $display("FAIL restart_state: got %0d expected 1", state_dbg); end
    n_checks++; if (config_out !== 40'h123456789A) begin n_fail++; $display("FAIL restart_config_held: got %h expected %h", config_out, 40'h123456789A); end
    step();
    n_checks++; if (error !== 1'b0) begin n_fail++; $display("FAIL restart_error_one_cycle: got %b expected 0", error); end
    for (int i = 1; i <= 5; i++) begin
      send_word(8'(i));
      if (done) done_count++;
    end
    step();
    if (done) done_count++;
    n_checks++; if (config_out !== 40'h0102030405) begin n_fail++; $display("FAIL restart_config: got %h expected %h", config_out, 40'h0102030405); end
    step();
    if (done) done_count++;
    n_checks++; if (done_count !== 1) begin n_fail++; $display("FAIL restart_done_count: got %0d expected 1", done_count); end
  endtask

  task automatic test_non_multiple();
    logic [39:0] img;
    img     = 40'hF123456789;
    start36 = 1'b1;
    step();
    start36 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      data36  = img[39-8*i -: 8];
      valid36 = 1'b1;
      step();
    end
    valid36 = 1'b0;
    n_checks++; if (config36 !== 36'h0) begin n_fail++; $display("FAIL nonmult_before_commit: got %h expected 0", config36); end
    step();
    n_checks++; if (config36 !== 36'h123456789) begin n_fail++; $display("FAIL nonmult_config: got %h expected %h", config36, 36'h123456789); end
    n_checks++; if (done36 !== 1'b1) begin n_fail++; $display("FAIL nonmult_done: got %b expected 1", done36); end
    step();
  endtask

  task automatic test_reset_mid_load();
    load_full(40'h123456789A);
    n_checks++; if (config_out !== 40'h123456789A) begin n_fail++; $display("FAIL midreset_prior: got %h expected %h", config_out, 40'h123456789A); end
    step();
    do_start();
    send_word(8'h55); send_word(8'h66);
    nreset = 1'b0;
    #2;
    n_checks++; if (config_out !== 40'h0) begin n_fail++; $display("FAIL midreset_config: got %h expected 0", config_out); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL midreset_state: got %0d expected 0", state_dbg); end
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL midreset_ready: got %b expected 0", data_ready); end
    step();
    nreset = 1'b1;
    step();
    load_full(40'h0A0B0C0D0E);
    n_checks++; if (config_out !== 40'h0A0B0C0D0E) begin n_fail++; $display("FAIL midreset_reload: got %h expected %h", config_out, 40'h0A0B0C0D0E); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL midreset_reload_done: got %b expected 1", done); end
    step();
  endtask

`ifdef CONFIG_READBACK_EN
  task automatic test_readback();
    logic [7:0]  exp_q[$];
    logic [39:0] old_img;
    logic [39:0] new_img;
    logic [7:0]  exp_w;
    old_img = 40'h123456789A;
    new_img = 40'h0102030405;
    apply_reset();
    load_full(old_img);
    step();
    for (int i = 0; i < 5; i++) exp_q.push_back(old_img[39-8*i -: 8]);
    do_start();
    for (int i = 0; i < 5; i++) begin
      send_word(new_img[39-8*i -: 8]);
      exp_w = exp_q.pop_front();
      n_checks++; if (readback_valid !== 1'b1) begin n_fail++; $display("FAIL readback_valid w%0d: got %b expected 1", i, readback_valid); end
      n_checks++; if (readback_out !== exp_w) begin n_fail++; $display("FAIL readback_word w%0d: got %h expected %h", i, readback_out, exp_w); end
    end
    step();
    n_checks++; if (readback_valid !== 1'b0) begin n_fail++; $display("FAIL readback_valid_drop: got %b expected 0", readback_valid); end
    n_checks++; if (config_out !== new_img) begin n_fail++; $display("FAIL readback_config: got %h expected %h", config_out, new_img); end
    step();
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    start = 1'b0; data_in = 8'h00; data_valid = 1'b0;
    start36 = 1'b0; data36 = 8'h00; valid36 = 1'b0;
    nreset = 1'b0;
    test_reset();
    test_basic_load();
    test_stalls();
    test_restart();
    test_non_multiple();
    test_reset_mid_load();
`ifdef CONFIG_READBACK_EN
    test_readback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/config_loader.md
# config_loader

Configuration loader for the tile fabric. It accepts a configuration bitstream as DATA_WIDTH-bit words over a valid/ready handshake and assembles them in a shadow register. It then commits the assembled image atomically to `config_out`, which drives the `config_in` selector fields of the fabric's multiplexers. Fabric muxes never see a partially loaded image.

## Interface
- `CONFIG_WIDTH`, 40, total configuration bits driven (e.g. ten 4-bit mux selectors)
- `DATA_WIDTH`, 8, bitstream word width
- Derived: WORDS = ceil(CONFIG_WIDTH/DATA_WIDTH); SHADOW_WIDTH = WORDS*DATA_WIDTH

Ports:
- `clock`  in  1  single clock; all state changes on rising edge
- `nreset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a load sequence
- `data_in`  in  DATA_WIDTH  bitstream word
- `data_valid`  in  1  `data_in` is valid
- `data_ready`  out  1  loader accepts a word this cycle
- `busy`  out  1  state is not IDLE
- `done`  out  1  one-cycle pulse; new image visible on `config_out`
- `error`  out  1  one-cycle pulse; load aborted by restart
- `config_out`  out  CONFIG_WIDTH  active configuration
- `readback_out`  out  DATA_WIDTH  old-image word; present only with CONFIG_READBACK_EN
- `readback_valid`  out  1  `readback_out` valid; present only with CONFIG_READBACK_EN

## Operation
- FSM states: IDLE, LOAD, COMMIT.
- **Reset:** state=IDLE; shadow=0; word count=0; `config_out`=0 (every mux selects input 0); `done`=`error`=`readback_valid`=0; `readback_out`=0.
- **IDLE:**
  - `start`=1 → LOAD.
  - Count is cleared.
  - Shadow is cleared to 0, or loaded with zero-extended `config_out` under CONFIG_READBACK_EN.
- **LOAD:**
  - `data_ready`=1 (combinational from state only).
  - A word is accepted on an edge where `data_valid`&&`data_ready`.
  - On accept: shadow <= {shadow[SHADOW_WIDTH-DATA_WIDTH-1:0], data_in}; count++.
  - The first word accepted ends up most significant.
  - Accept of word WORDS → COMMIT.
- **Restart in LOAD:** `start`=1 in LOAD takes priority over a simultaneous accept.
  - The word is discarded.
  - `error` pulses the next cycle.
  - Count and shadow are reinitialised as from IDLE; state stays LOAD.
- **COMMIT:**
  - `data_ready`=0.
  - Next edge: `config_out` <= shadow[CONFIG_WIDTH-1:0]; `done` <= 1; → IDLE.
  - `start` is ignored in COMMIT.
- **Non-multiple widths:** the upper SHADOW_WIDTH-CONFIG_WIDTH bits of the first word are discarded.
- **Stability:** `config_out` changes only at commit or reset; it never changes during LOAD.
- **Reset mid-load:** all state is lost and `config_out` returns to 0.

## Timing
- `data_ready` rises in the cycle after the edge that samples `start` in IDLE.
- Last word accepted at edge N → COMMIT during cycle N..N+1 → at edge N+1, `config_out` updates and `done`=1 for exactly one cycle.
- `busy` is high from the edge after `start` through the COMMIT cycle; it is low in the `done` cycle.
- Minimum load: WORDS+2 cycles from `start` to `done`.
- Unlimited `data_valid` stalls are allowed; there is no timeout.
- `error` is a registered one-cycle pulse.

## Configuration
- Macro: `CONFIG_READBACK_EN`.
- **Defined:**
  - Shadow is preloaded with the current `config_out` at `start` (and at restart).
  - On each accept, the DATA_WIDTH bits shifted out of the top of the shadow are registered to `readback_out`, with `readback_valid`=1 for one cycle.
  - WORDS accepts therefore stream out the full old image, most significant word first, zero-padded.
- **Undefined:** readback ports and logic are absent; shadow is cleared at `start`.

## Test plan
- **Basic load:** defaults; `start`, then words 0x12,0x34,0x56,0x78,0x9A back-to-back → `config_out`=0x123456789A at edge after COMMIT; `done` high 1 cycle; `busy` low after.
- **Stalls:** same words with `data_valid` low 3 cycles between each → identical `config_out`; `data_ready` stays high throughout LOAD; `config_out` unchanged (0) until commit.
- **Restart:** accept 0xAA,0xBB, then `start` → `error` pulse one cycle; then 0x01..0x05 → `config_out`=0x0102030405, single `done`.
- **Non-multiple width:** CONFIG_WIDTH=36; words 0xF1,0x23,0x45,0x67,0x89 → `config_out`=0x123456789.
- **Reset mid-operation:** reset mid-load after a prior commit of 0x123456789A → `config_out`=0, IDLE, `data_ready`=0; new full load succeeds.
- **Readback (CONFIG_READBACK_EN):** load 0x123456789A, then load 0x0102030405 → `readback_out` sequence 0x12,0x34,0x56,0x78,0x9A, one per accept; final `config_out`=0x0102030405.
